// File: rtl/fifo_pkg.sv
// Shared defaults, level-width helper and parameter legality check for the
// watermark FIFO.
package fifo_pkg;
  localparam int DEF_B      = 8;
  localparam int DEF_W      = 4;
  localparam int DEF_AE_LVL = 2;
  localparam int DEF_AF_LVL = 14;
  localparam int DEF_LVL_W  = DEF_W + 1;

  // Occupancy needs one extra bit to represent a completely full FIFO.
  function automatic int lvl_w(input int w);
    return w + 1;
  endfunction

  function automatic bit params_ok(input int w, input int ae, input int af);
    return (ae >= 0) && (ae < af) && (af <= (1 << w));
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } flags_t;
endpackage

// File: rtl/fifo_mem.sv
// 2**W x B storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally never reset.
module fifo_mem #(
  parameter int B = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         i_we,
  input  logic [W-1:0] i_waddr,
  input  logic [B-1:0] i_wdata,
  input  logic [W-1:0] i_raddr,
  output logic [B-1:0] o_rdata
);
  logic [B-1:0] r_mem [2**W];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/fifo_wm.sv
// Synchronous show-ahead FIFO with registered level, watermark flags,
// synchronous flush and sticky overflow/underflow.
module fifo_wm
  import fifo_pkg::*;
#(
  parameter int B      = DEF_B,
  parameter int W      = DEF_W,
  parameter int AE_LVL = DEF_AE_LVL,
  parameter int AF_LVL = DEF_AF_LVL
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         err_clr,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   level,
  output logic         overflow,
  output logic         underflow
);
  localparam int          LW    = lvl_w(W);
  localparam logic [LW-1:0] DEPTH = LW'(1 << W);
  localparam logic [LW-1:0] AE_V  = LW'(AE_LVL);
  localparam logic [LW-1:0] AF_V  = LW'(AF_LVL);

  generate
    if (!params_ok(W, AE_LVL, AF_LVL)) begin : g_bad_params
      $error("fifo_wm: illegal watermarks (need 0 <= AE_LVL < AF_LVL <= 2**W)");
    end
  endgenerate

  logic [W-1:0]  r_wptr, r_rptr;
  logic [LW-1:0] r_level, w_level_nxt;
  flags_t        r_flags, w_flags_nxt;
  logic          r_ovf, r_udf;
  logic          w_rd_ok, w_wr_ok, w_ovf_set, w_udf_set;

  // Flush suppresses both acceptance and error detection.
  assign w_rd_ok   = ~clr & rd & ~r_flags.empty;
  assign w_wr_ok   = ~clr & wr & (~r_flags.full | rd);
  assign w_ovf_set = ~clr & wr & r_flags.full & ~rd;
  assign w_udf_set = ~clr & rd & r_flags.empty;

  always_comb begin
    w_level_nxt = r_level;
    if (clr)
      w_level_nxt = '0;
    else if (w_wr_ok && !w_rd_ok)
      w_level_nxt = r_level + LW'(1);
    else if (w_rd_ok && !w_wr_ok)
      w_level_nxt = r_level - LW'(1);
  end

  // Flags come from the next level so they line up with level itself.
  always_comb begin
    w_flags_nxt.empty        = (w_level_nxt == '0);
    w_flags_nxt.full         = (w_level_nxt == DEPTH);
    w_flags_nxt.almost_empty = (w_level_nxt <= AE_V);
    w_flags_nxt.almost_full  = (w_level_nxt >= AF_V);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_flags <= '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0};
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (clr) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr_ok) r_wptr <= r_wptr + W'(1);
        if (w_rd_ok) r_rptr <= r_rptr + W'(1);
      end
      r_level <= w_level_nxt;
      r_flags <= w_flags_nxt;
      r_ovf   <= w_ovf_set | (r_ovf & ~err_clr);
      r_udf   <= w_udf_set | (r_udf & ~err_clr);
    end
  end

  fifo_mem #(.B(B), .W(W)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok & reset_n),
    .i_waddr (r_wptr),
    .i_wdata (w_data),
    .i_raddr (r_rptr),
    .o_rdata (r_data)
  );

  assign level        = r_level;
  assign empty        = r_flags.empty;
  assign full         = r_flags.full;
  assign almost_empty = r_flags.almost_empty;
  assign almost_full  = r_flags.almost_full;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;
endmodule

// File: tb/tb_fifo_wm.sv
// Scoreboard bench for fifo_wm: a queue-based reference model predicts the
// post-edge state; a separate monitor compares it after each edge.
module tb_fifo_wm;
  localparam int B = 8, W = 4, DEPTH = 16, AE = 2, AF = 14;

  logic         clk = 1'b0, reset_n = 1'b0, clr = 1'b0, rd = 1'b0, wr = 1'b0, err_clr = 1'b0;
  logic [B-1:0] w_data = '0;
  logic [B-1:0] r_data;
  logic         empty, full, almost_empty, almost_full, overflow, underflow;
  logic [W:0]   level;

  fifo_wm #(.B(B), .W(W), .AE_LVL(AE), .AF_LVL(AF)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .rd(rd), .wr(wr), .w_data(w_data),
    .err_clr(err_clr), .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          lvl;
    bit          emp, ful, ae, af, ov, uf;
    logic [7:0]  head;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mq[$];
  bit          m_ov = 0, m_uf = 0;
  int          cyc = 0;
  int          n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", tag, name, act, expv, cyc);
    end
  endtask

  // Monitor: checks every prediction whose edge has already happened.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk(e.tag, "level",        32'(level),        32'(e.lvl));
        chk(e.tag, "empty",        32'(empty),        32'(e.emp));
        chk(e.tag, "full",         32'(full),         32'(e.ful));
        chk(e.tag, "almost_empty", 32'(almost_empty), 32'(e.ae));
        chk(e.tag, "almost_full",  32'(almost_full),  32'(e.af));
        chk(e.tag, "overflow",     32'(overflow),     32'(e.ov));
        chk(e.tag, "underflow",    32'(underflow),    32'(e.uf));
        if (!e.emp) chk(e.tag, "r_data", 32'(r_data), 32'(e.head));
      end
    end
  end

  // Drive one cycle of requests, advance the model, and queue its prediction.
  task automatic step(input bit rn, input bit c, input bit r, input bit w,
                      input logic [7:0] d, input bit ec, input string tag);
    exp_t e;
    bit   rdok, wrok;
    reset_n = rn; clr = c; rd = r; wr = w; w_data = d; err_clr = ec;
    if (!rn) begin
      mq.delete(); m_ov = 0; m_uf = 0;
    end else begin
      if (ec) begin m_ov = 0; m_uf = 0; end
      if (c) mq.delete();
      else begin
        rdok = r && mq.size() > 0;
        wrok = w && (mq.size() < DEPTH || r);
        if (w && mq.size() == DEPTH && !r) m_ov = 1;
        if (r && mq.size() == 0) m_uf = 1;
        if (rdok) void'(mq.pop_front());
        if (wrok) mq.push_back(d);
      end
    end
    e.due  = cyc + 1;
    e.lvl  = mq.size();
    e.emp  = (mq.size() == 0);
    e.ful  = (mq.size() == DEPTH);
    e.ae   = (mq.size() <= AE);
    e.af   = (mq.size() >= AF);
    e.ov   = m_ov;
    e.uf   = m_uf;
    e.head = (mq.size() > 0) ? mq[0] : 8'h00;
    e.tag  = tag;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic wr1(input logic [7:0] d, input string tag); step(1, 0, 0, 1, d, 0, tag); endtask
  task automatic rd1(input string tag);                      step(1, 0, 1, 0, 8'h00, 0, tag); endtask

  initial begin
    int pw, pr;
    logic [7:0] d;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 8'h00, 0, "reset");
    step(0, 0, 1, 1, 8'h11, 0, "reset");

    for (int i = 0; i < 16; i++) wr1(8'(i), "fill");
    wr1(8'hEE, "overflow");
    for (int i = 0; i < 16; i++) rd1("drain");
    rd1("underflow");
    step(1, 0, 0, 0, 8'h00, 1, "err_clr");

    for (int i = 0; i < 16; i++) wr1(8'(8'h30 + i), "refill");
    step(1, 0, 1, 1, 8'hAA, 0, "full_rdwr");
    for (int i = 0; i < 16; i++) rd1("drain_aa");

    step(1, 0, 1, 1, 8'h55, 1, "empty_rdwr_clr");
    rd1("pop55");
    step(1, 0, 0, 0, 8'h00, 1, "err_clr2");

    wr1(8'h01, "wrap_prime");
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, 1, 8'($urandom), 0, "wrap_wr");
      step(1, 0, 1, 0, 8'h00, 0, "wrap_rd");
    end
    rd1("wrap_last");

    for (int i = 0; i < 16; i++) wr1(8'($urandom), "fill_ov");
    wr1(8'h77, "set_ov");
    for (int i = 0; i < 7; i++) rd1("down_to_9");
    step(1, 1, 0, 1, 8'h99, 0, "clr_at_9");
    rd1("after_clr");

    for (int i = 0; i < 10; i++) wr1(8'($urandom), "burst");
    step(0, 0, 1, 1, 8'h42, 0, "reset_mid");
    step(1, 0, 0, 0, 8'h00, 0, "post_reset");

    pw = 50; pr = 50;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin pw = $urandom_range(10, 90); pr = $urandom_range(10, 90); end
      d = 8'($urandom);
      step(($urandom_range(0, 399) != 0), ($urandom_range(0, 63) == 0),
           ($urandom_range(0, 99) < pr), ($urandom_range(0, 99) < pw), d,
           ($urandom_range(0, 31) == 0), "random");
    end

    step(1, 0, 0, 0, 8'h00, 0, "idle");
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard.drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
